demux1x2_buffered: RTL

Sequential 1-to-2 demultiplexer: steers a WIDTH-bit data stream from one valid/ready source to one of two valid/ready sinks, chosen per transfer by a select bit. Each sink has its own 2-entry FIFO, so a stalled sink never blocks traffic to the other. Sits in the datapath wherever one producer stage feeds two independently stalling consumers. It is the inverse of the existing 2:1 enabled mux.

---
 rtl/demux1x2_buffered_if.sv | 35 +++
 rtl/demux1x2_buffered.sv | 110 +++++++++++
 2 files changed

// File: rtl/demux1x2_buffered_if.sv
// Handshake bundle for the buffered 1:2 demultiplexer: one valid/ready source side,
// two valid/ready sink sides and the per-port delivery counters.
interface demux1x2_buffered_if #(
   parameter int unsigned WIDTH = 4
);
   localparam int unsigned CNT_W = 8;

   logic             E;
   logic             in_valid;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [WIDTH-1:0] out1_data;

   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   // Environment side: drives the source and the sink readies.
   modport master (
      output E, in_valid, in_sel, in_data, out0_ready, out1_ready,
      input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
   );

   // Demultiplexer side.
   modport slave (
      input  E, in_valid, in_sel, in_data, out0_ready, out1_ready,
      output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
   );
endinterface

// File: rtl/demux1x2_buffered.sv
// Sequential 1:2 demultiplexer: each input word is steered by in_sel into one of two
// independent 2-entry FIFOs, so a stalled sink never blocks traffic to the other.
module demux1x2_buffered #(
   parameter int unsigned WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   demux1x2_buffered_if.slave bus
);
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned N_PORTS = 2;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } fifo_state_e;

   fifo_state_e      r_state    [N_PORTS];
   fifo_state_e      w_state_nxt[N_PORTS];
   logic [WIDTH-1:0] r_head     [N_PORTS];
   logic [WIDTH-1:0] w_head_nxt [N_PORTS];
   logic [WIDTH-1:0] r_tail     [N_PORTS];
   logic [WIDTH-1:0] w_tail_nxt [N_PORTS];
   logic [CNT_W-1:0] r_cnt      [N_PORTS];
   logic [CNT_W-1:0] w_cnt_nxt  [N_PORTS];

   logic             w_out_ready[N_PORTS];
   logic             w_push     [N_PORTS];
   logic             w_pop      [N_PORTS];
   logic             w_in_ready;

   assign w_out_ready[0] = bus.out0_ready;
   assign w_out_ready[1] = bus.out1_ready;

   // Only the selected FIFO's fullness gates acceptance; no path from the sink readies.
   assign w_in_ready = bus.E && (r_state[bus.in_sel] != ST_TWO);

   // Next-state and datapath for both FIFOs.
   always_comb begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
         w_state_nxt[p] = r_state[p];
         w_head_nxt[p]  = r_head[p];
         w_tail_nxt[p]  = r_tail[p];
         w_cnt_nxt[p]   = r_cnt[p];
         w_push[p]      = bus.in_valid && w_in_ready && (bus.in_sel == 1'(p));
         w_pop[p]       = (r_state[p] != ST_EMPTY) && w_out_ready[p];

         case (r_state[p])
            ST_EMPTY: begin
               if (w_push[p]) begin
                  w_state_nxt[p] = ST_ONE;
                  w_head_nxt[p]  = bus.in_data;
               end
            end
            ST_ONE: begin
               if (w_push[p] && w_pop[p]) begin
                  w_head_nxt[p] = bus.in_data;
               end else if (w_push[p]) begin
                  w_state_nxt[p] = ST_TWO;
                  w_tail_nxt[p]  = bus.in_data;
               end else if (w_pop[p]) begin
                  w_state_nxt[p] = ST_EMPTY;
               end
            end
            ST_TWO: begin
               // A push is impossible here because in_ready is low for this port.
               if (w_pop[p]) begin
                  w_state_nxt[p] = ST_ONE;
                  w_head_nxt[p]  = r_tail[p];
               end
            end
            default: begin
               w_state_nxt[p] = ST_EMPTY;
            end
         endcase

         if (w_pop[p]) begin
            w_cnt_nxt[p] = r_cnt[p] + CNT_W'(1);
         end
      end
   end

   // State registers; reset discards any buffered words.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < int'(N_PORTS); p++) begin
            r_state[p] <= ST_EMPTY;
            r_head[p]  <= '0;
            r_tail[p]  <= '0;
            r_cnt[p]   <= '0;
         end
      end else begin
         for (int p = 0; p < int'(N_PORTS); p++) begin
            r_state[p] <= w_state_nxt[p];
            r_head[p]  <= w_head_nxt[p];
            r_tail[p]  <= w_tail_nxt[p];
            r_cnt[p]   <= w_cnt_nxt[p];
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out0_valid = (r_state[0] != ST_EMPTY);
   assign bus.out1_valid = (r_state[1] != ST_EMPTY);
   assign bus.out0_data  = r_head[0];
   assign bus.out1_data  = r_head[1];
   assign bus.cnt0       = r_cnt[0];
   assign bus.cnt1       = r_cnt[1];
endmodule
